// File: rtl/alu_op_scheduler.sv
// Round-robin arbiter/sequencer that owns the select of the registered ALU result mux.
// Define ALU_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module alu_op_scheduler #(
  parameter int N_REQ  = 4,
  parameter int SEL_W  = 3,
  parameter int DATA_W = 16
) (
  input  logic                   CK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*SEL_W-1:0] op,
  input  logic [DATA_W-1:0]      mux_out,
  output logic [SEL_W-1:0]       sel,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [DATA_W-1:0]      result,
  output logic [N_REQ-1:0]       result_valid
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // state | meaning
  // IDLE  | waiting for any request; arbitrate on the edge one is seen
  // ISSUE | select driven, mux registers its inputs on this edge
  // WAIT  | mux output valid, captured on this edge
  // DONE  | result_valid pulse to the owner, then release
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [N_REQ-1:0]   rv_q, rv_d;

  logic               found;
  logic [PTR_W-1:0]   win_idx;
  logic [SEL_W-1:0]   win_op;

`ifdef ALU_SCHED_FIXED_PRIO_EN
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found   = 1'b1;
        win_idx = PTR_W'(i);
      end
    end
  end
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Search starts just after the last winner and ends at it.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [PTR_W-1:0] idx;
      idx = PTR_W'((int'(ptr_q) + k) % N_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && found) ptr_d = win_idx;
  end

  always_ff @(posedge CK) begin
    if (RST) ptr_q <= PTR_W'(N_REQ - 1);
    else     ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    win_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PTR_W'(i)) win_op = op[i*SEL_W +: SEL_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    result_d = result_q;
    rv_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          sel_d   = win_op;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        result_d = mux_out;
        rv_d     = grant_q;
        state_d  = DONE;
      end
      DONE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      result_q <= '0;
      rv_q     <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  assign sel          = sel_q;
  assign grant        = grant_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scoreboard bench for alu_op_scheduler with a registered 8-way mux model (input i = 16'h00A0 + i).
module tb_alu_op_scheduler;
  localparam int N  = 4;
  localparam int SW = 3;
  localparam int DW = 16;

  logic          CK = 1'b0;
  logic          RST;
  logic [N-1:0]  req;
  logic [N*SW-1:0] op;
  logic [DW-1:0] mux_out;
  logic [SW-1:0] sel;
  logic [N-1:0]  grant;
  logic          busy;
  logic [DW-1:0] result;
  logic [N-1:0]  result_valid;

  typedef struct packed {
    logic [N-1:0]  rv;
    logic [DW-1:0] res;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  alu_op_scheduler #(.N_REQ(N), .SEL_W(SW), .DATA_W(DW)) dut (
    .CK(CK), .RST(RST), .req(req), .op(op), .mux_out(mux_out),
    .sel(sel), .grant(grant), .busy(busy), .result(result),
    .result_valid(result_valid)
  );

  always #5 CK = ~CK;

  always_ff @(posedge CK) mux_out <= 16'h00A0 + {13'd0, sel};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge CK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [SW-1:0] v);
    op[i*SW +: SW] = v;
  endtask

  task automatic push(input logic [N-1:0] rv, input logic [DW-1:0] res);
    exp_t e;
    e.rv  = rv;
    e.res = res;
    sb_q.push_back(e);
  endtask

  // Monitor: every result_valid pulse must match the oldest expected entry.
  always @(negedge CK) begin
    if (result_valid != '0) begin
      n_chk++;
      if ($countones(result_valid) != 1) begin
        n_fail++;
        $display("FAIL rv_onehot: got %b expected one-hot", result_valid);
      end else if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL rv_unexpected: got rv=%b result=%h expected no pulse", result_valid, result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (result_valid !== e.rv || result !== e.res) begin
          n_fail++;
          $display("FAIL sb_result: got rv=%b res=%h expected rv=%b res=%h",
                   result_valid, result, e.rv, e.res);
        end
      end
    end
    if ($countones(grant) > 1) begin
      n_chk++;
      n_fail++;
      $display("FAIL grant_onehot: got %b expected at most one bit", grant);
    end
  end

  initial begin
    logic [N-1:0] exp_g;
    RST = 1'b1;
    req = '0;
    op  = '0;
    step(2);
    RST = 1'b0;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_rv", 32'(result_valid), 0);

    // single request: latency and hold
    req = 4'b0001;
    set_op(0, 3'b101);
    push(4'b0001, 16'h00A5);
    step(1);
    chk("t1_sel", 32'(sel), 5);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_busy", 32'(busy), 1);
    req = '0;
    step(1);
    chk("t1_wait_grant", 32'(grant), 32'h1);
    chk("t1_wait_busy", 32'(busy), 1);
    chk("t1_wait_rv", 32'(result_valid), 0);
    step(1);
    chk("t1_done_rv", 32'(result_valid), 32'h1);
    chk("t1_done_res", 32'(result), 32'h00A5);
    chk("t1_done_busy", 32'(busy), 1);
    step(1);
    chk("t1_clr_grant", 32'(grant), 0);
    chk("t1_clr_busy", 32'(busy), 0);
    chk("t1_clr_rv", 32'(result_valid), 0);
    chk("t1_hold_res", 32'(result), 32'h00A5);

    // rotation with all requesters held
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, SW'(i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (k % N);
`endif
      push(exp_g, 16'h00A0 + 16'($clog2(exp_g)));
    end
    for (int k = 0; k < 5; k++) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (k % N);
`endif
      step(1);
      chk($sformatf("rr_grant%0d", k), 32'(grant), 32'(exp_g));
      if (k == 4) req = '0;
      step(3);
    end

    // reset during WAIT aborts without a pulse
    req = 4'b0100;
    step(1);
    chk("ab_grant", 32'(grant), 32'h4);
    req = '0;
    step(1);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    chk("ab_sel", 32'(sel), 0);
    chk("ab_grant0", 32'(grant), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_result", 32'(result), 0);
    chk("ab_rv", 32'(result_valid), 0);
    req = 4'b1010;
    push(4'b0010, 16'h00A1);
    step(1);
    chk("ab_regrant", 32'(grant), 32'h2);
    req = '0;
    step(2);
    chk("drop_rv", 32'(result_valid), 32'h2);
    chk("drop_res", 32'(result), 32'h00A1);
    step(1);

    // opcode changed after grant is ignored
    set_op(2, 3'b010);
    req = 4'b0100;
    push(4'b0100, 16'h00A2);
    step(1);
    chk("opc_sel_issue", 32'(sel), 2);
    set_op(2, 3'b111);
    req = '0;
    step(1);
    chk("opc_sel_wait", 32'(sel), 2);
    step(1);
    chk("opc_sel_done", 32'(sel), 2);
    chk("opc_res", 32'(result), 32'h00A2);
    step(4);
    chk("sb_empty", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
